// File: rtl/led_playback_sequencer_if.sv
// Sequence-memory read port between the playback sequencer (master) and the sequence RAM (slave).
// Handshake: mem_rd is a one-cycle read strobe with mem_addr valid in the same cycle. mem_data is valid
// the following cycle. There is no ready/backpressure, because the RAM always accepts a strobe.
interface led_playback_sequencer_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 4
);
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;

    modport master (output mem_rd, output mem_addr, input  mem_data);
    modport slave  (input  mem_rd, input  mem_addr, output mem_data);
endinterface

// File: rtl/led_playback_sequencer.sv
// Plays the stored colour sequence on the LEDs: fetch, show for on_time, blank for a gap, repeat, pulse done.
// Optional buzzer tone while an item is lit: define PLAYBACK_TONE_EN.
module led_playback_sequencer #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 25,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int TONE_BASE  = 50_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_WIDTH:0]     len,
    input  logic                    speed,
    led_playback_sequencer_if.master mem_bus,
    output logic [DATA_WIDTH-1:0]   led_out,
    output logic                    busy,
    output logic                    done,
    output logic                    tone_out,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_ON    = 3'd3,
        S_OFF   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  ON_LOAD_FULL = CNT_WIDTH'(ON_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  ON_LOAD_HALF = CNT_WIDTH'((ON_CYCLES >> 1) - 1);
    localparam logic [CNT_WIDTH-1:0]  OFF_LOAD     = CNT_WIDTH'(OFF_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE      = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE      = (ADDR_WIDTH+1)'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic                    speed_q, speed_d;
    logic [CNT_WIDTH-1:0]    timer_q, timer_d;
    logic [DATA_WIDTH-1:0]   led_q, led_d;
    logic                    mem_rd_q, mem_rd_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    last_item;

    assign last_item = ({1'b0, idx_q} == (len_q - LEN_ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            speed_q    <= 1'b0;
            timer_q    <= '0;
            led_q      <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            speed_q    <= speed_d;
            timer_q    <= timer_d;
            led_q      <= led_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        speed_d    = speed_q;
        timer_d    = timer_q;
        led_d      = led_q;
        mem_addr_d = mem_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (len != '0) begin
                        state_d = S_FETCH;
                        len_d   = len;
                        speed_d = speed;
                        idx_d   = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                led_d   = mem_bus.mem_data;
                timer_d = speed_q ? ON_LOAD_HALF : ON_LOAD_FULL;
                state_d = S_ON;
            end
            S_ON: begin
                if (timer_q == '0) begin
                    led_d   = '0;
                    timer_d = OFF_LOAD;
                    state_d = S_OFF;
                end else begin
                    timer_d = timer_q - CNT_ONE;
                end
            end
            S_OFF: begin
                if (timer_q == '0) begin
                    if (last_item) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = S_FETCH;
                    end
                end else begin
                    timer_d = timer_q - CNT_ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides any timer event and suppresses the done pulse.
        if (abort) begin
            state_d = S_IDLE;
            led_d   = '0;
            timer_d = '0;
        end

        if (state_d == S_FETCH) begin
            mem_addr_d = idx_d;
        end
        mem_rd_d = (state_d == S_FETCH);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    assign mem_bus.mem_rd   = mem_rd_q;
    assign mem_bus.mem_addr = mem_addr_q;
    assign led_out          = led_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign dbg_state        = state_q;

`ifdef PLAYBACK_TONE_EN
    localparam int TONE_MAX = TONE_BASE << (DATA_WIDTH - 1);
    localparam int TONE_W   = $clog2(TONE_MAX + 1);
    localparam logic [TONE_W-1:0] TONE_ONE = TONE_W'(1);

    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic [TONE_W-1:0] tone_half;
    logic              tone_q, tone_d;
    int                tone_k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
        end
    end

    // Half-period doubles per colour bit; a blank item falls back to bit 0.
    always_comb begin
        tone_k = 0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (led_q[i]) tone_k = i;
        end
        tone_half  = TONE_W'(TONE_BASE) << tone_k;
        tone_cnt_d = '0;
        tone_d     = 1'b0;
        if (state_q == S_ON && state_d == S_ON) begin
            if (tone_cnt_q == tone_half - TONE_ONE) begin
                tone_d = ~tone_q;
            end else begin
                tone_cnt_d = tone_cnt_q + TONE_ONE;
                tone_d     = tone_q;
            end
        end
    end

    assign tone_out = tone_q;
`else
    logic unused_tone_base;
    assign unused_tone_base = ^TONE_BASE;
    assign tone_out         = 1'b0;
`endif

endmodule
